// File: rtl/dsp48a1_slice.sv
// dsp48a1_slice
// Spartan-6 DSP48A1-style arithmetic slice: 18-bit pre-adder feeding an 18x18
// unsigned multiplier, then a 48-bit post-adder/accumulator with carry in/out.
// Every stage has an optional pipeline register; a bypassed stage is purely
// combinational.
//
// Configuration macro: DSP_CASCADE_EN
//   defined     -> BCOUT/PCOUT carry the B1 and P values, and B_INPUT="CASCADE"
//                  selects BCIN as the B source.
//   not defined -> BCOUT=0, PCOUT=0, BCIN ignored (B always taken from B).
//
// Ports
//   CLK                       rising-edge clock for every register
//   RSTA..RSTOPMODE           synchronous active-low per-stage resets (win over CE)
//   CEA..CEOPMODE             active-high per-stage clock enables
//   A, B, BCIN, D   [17:0]    multiplier / pre-adder operands
//   C, PCIN         [47:0]    post-adder operand / cascaded P input
//   CARRYIN                   external carry-in
//   OPMODE          [7:0]     operation select
//   BCOUT           [17:0]    B1 stage value
//   M               [35:0]    multiplier stage value
//   P, PCOUT        [47:0]    result and its cascade copy
//   CARRYOUT, CARRYOUTF       post-adder carry (bit 48) and its copy
module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [17:0] BCOUT,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

`ifdef DSP_CASCADE_EN
    localparam bit CASCADE_ON = 1'b1;
`else
    localparam bit CASCADE_ON = 1'b0;
`endif

    localparam bit USE_BCIN      = CASCADE_ON && (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

    logic [7:0]  opmode_q, opmode_d, opmode;
    logic [17:0] a0_q, a0_d, a0;
    logic [17:0] a1_q, a1_d, a1;
    logic [17:0] b0_q, b0_d, b0;
    logic [17:0] b1_q, b1_d, b1;
    logic [17:0] d_q, d_d, d;
    logic [47:0] c_q, c_d, c;
    logic [35:0] m_q, m_d, m;
    logic        cin_q, cin_d, cin;
    logic [47:0] p_q, p_d;
    logic        carry_q, carry_d;

    logic [17:0] b_src;
    logic [17:0] pre_sum;
    logic [35:0] mult;
    logic [47:0] x_mux, z_mux;
    logic [48:0] addend, post_sum;

    // Each stage output is either its register or the stage input passed straight through.
    assign opmode = (OPMODEREG  != 0) ? opmode_q : OPMODE;
    assign a0     = (A0REG      != 0) ? a0_q     : A;
    assign a1     = (A1REG      != 0) ? a1_q     : a0;
    assign b_src  = USE_BCIN ? BCIN : B;
    assign b0     = (B0REG      != 0) ? b0_q     : b_src;
    assign b1     = (B1REG      != 0) ? b1_q     : pre_sum;
    assign d      = (DREG       != 0) ? d_q      : D;
    assign c      = (CREG       != 0) ? c_q      : C;
    assign m      = (MREG       != 0) ? m_q      : mult;
    assign cin    = (CARRYINREG != 0) ? cin_q    : (CIN_FROM_PORT ? CARRYIN : opmode[5]);

    // Arithmetic datapath: pre-adder, multiplier, X/Z muxes and the 49-bit post-adder.
    // In subtract mode the carry-in joins X before being subtracted from Z.
    always_comb begin
        pre_sum = b0;
        if (opmode[4]) begin
            pre_sum = opmode[6] ? (d - b0) : (d + b0);
        end

        mult = {18'd0, a1} * {18'd0, b1};

        case (opmode[1:0])
            2'd0:    x_mux = '0;
            2'd1:    x_mux = {12'd0, m};
            2'd2:    x_mux = p_q;
            default: x_mux = {d[11:0], a1, b1};
        endcase

        case (opmode[3:2])
            2'd0:    z_mux = '0;
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = p_q;
            default: z_mux = C_sel(c);
        endcase

        addend   = {1'b0, x_mux} + {48'd0, cin};
        post_sum = opmode[7] ? ({1'b0, z_mux} - addend) : ({1'b0, z_mux} + addend);
    end

    function automatic logic [47:0] C_sel(input logic [47:0] v);
        return v;
    endfunction

    // Next-state for every register: hold unless its clock enable is high.
    always_comb begin
        opmode_d = opmode_q;
        a0_d     = a0_q;
        a1_d     = a1_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        d_d      = d_q;
        c_d      = c_q;
        m_d      = m_q;
        cin_d    = cin_q;
        p_d      = p_q;
        carry_d  = carry_q;
        if (CEOPMODE) opmode_d = OPMODE;
        if (CEA) begin
            a0_d = A;
            a1_d = a0;
        end
        if (CEB) begin
            b0_d = b_src;
            b1_d = pre_sum;
        end
        if (CED) d_d = D;
        if (CEC) c_d = C;
        if (CEM) m_d = mult;
        if (CECARRYIN) cin_d = CIN_FROM_PORT ? CARRYIN : opmode[5];
        if (CEP) begin
            p_d     = post_sum[47:0];
            carry_d = post_sum[48];
        end
    end

    // Per-stage synchronous resets; a reset only clears its own stage.
    always_ff @(posedge CLK) begin
        if (!RSTOPMODE) opmode_q <= '0;
        else            opmode_q <= opmode_d;

        if (!RSTA) begin
            a0_q <= '0;
            a1_q <= '0;
        end else begin
            a0_q <= a0_d;
            a1_q <= a1_d;
        end

        if (!RSTB) begin
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            b0_q <= b0_d;
            b1_q <= b1_d;
        end

        if (!RSTD) d_q <= '0;
        else       d_q <= d_d;

        if (!RSTC) c_q <= '0;
        else       c_q <= c_d;

        if (!RSTM) m_q <= '0;
        else       m_q <= m_d;

        if (!RSTCARRYIN) cin_q <= 1'b0;
        else             cin_q <= cin_d;

        if (!RSTP) begin
            p_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            carry_q <= carry_d;
        end
    end

    assign M         = m;
    assign P         = (PREG != 0) ? p_q : post_sum[47:0];
    assign CARRYOUT  = (CARRYOUTREG != 0) ? carry_q : post_sum[48];
    assign CARRYOUTF = CARRYOUT;
    assign BCOUT     = CASCADE_ON ? b1 : 18'd0;
    assign PCOUT     = CASCADE_ON ? P  : 48'd0;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb_dsp48a1_slice
// Drives two slices from the same stimulus: one with default pipelining and one
// with every stage bypassed. Outputs are predicted from the arithmetic rules and
// the per-input path latencies (count of enabled stages from input to output).
module tb_dsp48a1_slice;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        ce_all;
    logic        ce_p;
    logic [17:0] a_in, b_in, bcin_in, d_in;
    logic [47:0] c_in, pcin_in;
    logic        carryin_in;
    logic [7:0]  opmode_in;

    logic [17:0] pp_bcout, cc_bcout;
    logic [35:0] pp_m, cc_m;
    logic [47:0] pp_p, cc_p, pp_pcout, cc_pcout;
    logic        pp_co, cc_co, pp_cof, cc_cof;

    int tests_run    = 0;
    int tests_failed = 0;
    bit rand_phase   = 1'b0;
    int epoch        = 0;
    int negedge_count = 0;

    // Input history indexed by the clock edge that samples those inputs.
    logic [17:0] h_a [DEPTH];
    logic [17:0] h_b [DEPTH];
    logic [17:0] h_d [DEPTH];
    logic [47:0] h_c [DEPTH];
    logic [47:0] h_pcin [DEPTH];
    logic [7:0]  h_op [DEPTH];
    int          h_epoch [DEPTH];

    dsp48a1_slice dut_pipe (
        .CLK(clk), .RSTA(rst_n), .RSTB(rst_n), .RSTM(rst_n), .RSTP(rst_n), .RSTC(rst_n),
        .RSTD(rst_n), .RSTCARRYIN(rst_n), .RSTOPMODE(rst_n),
        .CEA(ce_all), .CEB(ce_all), .CEM(ce_all), .CEP(ce_p), .CEC(ce_all), .CED(ce_all),
        .CECARRYIN(ce_all), .CEOPMODE(ce_all),
        .A(a_in), .B(b_in), .BCIN(bcin_in), .D(d_in), .C(c_in), .PCIN(pcin_in),
        .CARRYIN(carryin_in), .OPMODE(opmode_in),
        .BCOUT(pp_bcout), .M(pp_m), .P(pp_p), .PCOUT(pp_pcout), .CARRYOUT(pp_co), .CARRYOUTF(pp_cof)
    );

    dsp48a1_slice #(
        .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .CREG(0), .DREG(0), .MREG(0),
        .PREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .OPMODEREG(0)
    ) dut_comb (
        .CLK(clk), .RSTA(rst_n), .RSTB(rst_n), .RSTM(rst_n), .RSTP(rst_n), .RSTC(rst_n),
        .RSTD(rst_n), .RSTCARRYIN(rst_n), .RSTOPMODE(rst_n),
        .CEA(ce_all), .CEB(ce_all), .CEM(ce_all), .CEP(ce_all), .CEC(ce_all), .CED(ce_all),
        .CECARRYIN(ce_all), .CEOPMODE(ce_all),
        .A(a_in), .B(b_in), .BCIN(bcin_in), .D(d_in), .C(c_in), .PCIN(pcin_in),
        .CARRYIN(carryin_in), .OPMODE(opmode_in),
        .BCOUT(cc_bcout), .M(cc_m), .P(cc_p), .PCOUT(cc_pcout), .CARRYOUT(cc_co), .CARRYOUTF(cc_cof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] model_pre(input logic [7:0] op, input logic [17:0] d, input logic [17:0] b);
        if (!op[4]) return b;
        return op[6] ? d - b : d + b;
    endfunction

    function automatic logic [48:0] model_post(input logic [7:0] op, input logic [47:0] x,
                                               input logic [47:0] z, input logic cin);
        logic [48:0] zz, xx;
        zz = {1'b0, z};
        xx = {1'b0, x} + {48'd0, cin};
        return op[7] ? zz - xx : zz + xx;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                                 input logic [17:0] d, input logic [47:0] c);
        opmode_in = op;
        a_in      = a;
        b_in      = b;
        d_in      = d;
        c_in      = c;
    endtask

    // Records upcoming inputs and checks both slices against the model every cycle.
    always @(negedge clk) begin : compare_proc
        logic [17:0] pre_m;
        logic [35:0] m_m;
        logic [47:0] x_m, z_m, bc_exp;
        logic [48:0] sum_m;
        logic [7:0]  op;
        int k;
        negedge_count++;
        k = negedge_count;
        if (k + 1 < DEPTH) begin
            h_a[k+1]     = a_in;
            h_b[k+1]     = b_in;
            h_d[k+1]     = d_in;
            h_c[k+1]     = c_in;
            h_pcin[k+1]  = pcin_in;
            h_op[k+1]    = opmode_in;
            h_epoch[k+1] = rand_phase ? epoch : 0;
        end

        if (rand_phase) begin
            pre_m = model_pre(opmode_in, d_in, b_in);
            m_m   = {18'd0, a_in} * {18'd0, pre_m};
            x_m   = (opmode_in[1:0] == 2'd1) ? {12'd0, m_m} :
                    (opmode_in[1:0] == 2'd3) ? {d_in[11:0], a_in, pre_m} : 48'd0;
            z_m   = (opmode_in[3:2] == 2'd1) ? pcin_in : (opmode_in[3:2] == 2'd3) ? c_in : 48'd0;
            sum_m = model_post(opmode_in, x_m, z_m, opmode_in[5]);
`ifdef DSP_CASCADE_EN
            bc_exp = {30'd0, pre_m};
`else
            bc_exp = 48'd0;
            sum_m  = sum_m;
`endif
            checkOutput("comb P", 64'(cc_p), 64'(sum_m[47:0]));
            checkOutput("comb M", 64'(cc_m), 64'(m_m));
            checkOutput("comb CARRYOUT", 64'(cc_co), 64'(sum_m[48]));
            checkOutput("comb CARRYOUTF", 64'(cc_cof), 64'(sum_m[48]));
            checkOutput("comb BCOUT", 64'(cc_bcout), 64'(bc_exp));
        end

        if (k >= 4 && k < DEPTH && h_epoch[k] != 0 && h_epoch[k-1] == h_epoch[k] &&
            h_epoch[k-2] == h_epoch[k] && h_epoch[k-3] == h_epoch[k]) begin
            op = h_op[k];
            // Path latencies: A,B -> P is 3 stages, D -> P is 4, C -> P is 2, PCIN -> P is 1.
            pre_m = model_pre(op, h_d[k-3], h_b[k-2]);
            m_m   = {18'd0, h_a[k-2]} * {18'd0, pre_m};
            x_m   = (op[1:0] == 2'd1) ? {12'd0, m_m} : 48'd0;
            z_m   = (op[3:2] == 2'd1) ? h_pcin[k] : (op[3:2] == 2'd3) ? h_c[k-1] : 48'd0;
            sum_m = model_post(op, x_m, z_m, op[5]);
            checkOutput("pipe P", 64'(pp_p), 64'(sum_m[47:0]));
            checkOutput("pipe CARRYOUT", 64'(pp_co), 64'(sum_m[48]));
            pre_m = model_pre(op, h_d[k-2], h_b[k-1]);
            m_m   = {18'd0, h_a[k-1]} * {18'd0, pre_m};
            checkOutput("pipe M", 64'(pp_m), 64'(m_m));
`ifdef DSP_CASCADE_EN
            checkOutput("pipe BCOUT", 64'(pp_bcout), 64'(model_pre(op, h_d[k-1], h_b[k])));
            checkOutput("pipe PCOUT", 64'(pp_pcout), 64'(sum_m[47:0]));
`else
            checkOutput("pipe BCOUT", 64'(pp_bcout), 64'd0);
            checkOutput("pipe PCOUT", 64'(pp_pcout), 64'd0);
`endif
        end
    end

    initial begin
        rst_n      = 1'b0;
        ce_all     = 1'b1;
        ce_p       = 1'b1;
        bcin_in    = 18'h2AAAA;
        pcin_in    = 48'd0;
        carryin_in = 1'b0;
        applyStimulus(8'h1D, 18'd5, 18'd6, 18'd8, 48'd9);

        // Reset held with live operands: the pipelined slice must stay at zero.
        step();
        step();
        @(negedge clk);
        checkOutput("reset P", 64'(pp_p), 64'd0);
        checkOutput("reset M", 64'(pp_m), 64'd0);
        checkOutput("reset BCOUT", 64'(pp_bcout), 64'd0);
        checkOutput("reset CARRYOUT", 64'(pp_co), 64'd0);
        rst_n = 1'b1;

        // Hand-computed results on the fully combinational slice.
        applyStimulus(8'h1D, 18'd5, 18'd6, 18'd8, 48'd9);
        @(negedge clk);
        checkOutput("lit P 79", 64'(cc_p), 64'd79);
        checkOutput("lit M 70", 64'(cc_m), 64'd70);
        checkOutput("lit CARRYOUT 0", 64'(cc_co), 64'd0);
        applyStimulus(8'h1D, 18'd10, 18'd7, 18'd8, 48'd10);
        @(negedge clk);
        checkOutput("lit P 160", 64'(cc_p), 64'd160);
        applyStimulus(8'h1D, 18'd110, 18'd78, 18'd588, 48'd160);
        @(negedge clk);
        checkOutput("lit P 73420", 64'(cc_p), 64'd73420);
        applyStimulus(8'h5D, 18'd3, 18'd5, 18'd20, 48'd1);
        @(negedge clk);
        checkOutput("lit pre-sub M 45", 64'(cc_m), 64'd45);
        checkOutput("lit pre-sub P 46", 64'(cc_p), 64'd46);
        applyStimulus(8'h7D, 18'd3, 18'd5, 18'd20, 48'd1);
        @(negedge clk);
        checkOutput("lit carry P 47", 64'(cc_p), 64'd47);
        applyStimulus(8'h03, 18'd2, 18'd3, 18'd1, 48'd0);
        @(negedge clk);
        checkOutput("lit X concat P", 64'(cc_p), 64'h0010_0008_0003);

        // Mid-operation reset, then the longest path (D) needs 4 edges.
        step();
        applyStimulus(8'h1D, 18'd5, 18'd6, 18'd8, 48'd9);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        checkOutput("mid reset P", 64'(pp_p), 64'd0);
        checkOutput("mid reset M", 64'(pp_m), 64'd0);
        checkOutput("mid reset CARRYOUT", 64'(pp_co), 64'd0);
        rst_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        checkOutput("latency P 79", 64'(pp_p), 64'd79);
        checkOutput("latency M 70", 64'(pp_m), 64'd70);

        // Load P from C, then accumulate +1 through the carry with single CEP pulses.
        step();
        applyStimulus(8'h0C, 18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF);
        repeat (3) step();
        @(negedge clk);
        checkOutput("load P all ones", 64'(pp_p), 64'hFFFF_FFFF_FFFF);
        checkOutput("load CARRYOUT", 64'(pp_co), 64'd0);
        ce_p      = 1'b0;
        opmode_in = 8'h28;
        repeat (3) step();
        c_in = 48'd5;
        a_in = 18'd99;
        @(negedge clk);
        checkOutput("CEP hold P", 64'(pp_p), 64'hFFFF_FFFF_FFFF);
        ce_p = 1'b1;
        step();
        ce_p = 1'b0;
        @(negedge clk);
        checkOutput("accum wrap P", 64'(pp_p), 64'd0);
        checkOutput("accum wrap CARRYOUT", 64'(pp_co), 64'd1);
        checkOutput("accum wrap CARRYOUTF", 64'(pp_cof), 64'd1);
        c_in = 48'd123;
        d_in = 18'd77;
        repeat (2) step();
        @(negedge clk);
        checkOutput("CEP hold after wrap", 64'(pp_p), 64'd0);
        ce_p = 1'b1;
        step();
        @(negedge clk);
        checkOutput("accum next P", 64'(pp_p), 64'd1);
        checkOutput("accum next CARRYOUT", 64'(pp_co), 64'd0);

        // Randomized bursts; OPMODE is constant within each burst.
        step();
        rand_phase = 1'b1;
        for (int burst = 0; burst < 30; burst++) begin
            logic [1:0] zsel;
            epoch++;
            case ($urandom_range(0, 2))
                0:       zsel = 2'd0;
                1:       zsel = 2'd1;
                default: zsel = 2'd3;
            endcase
            opmode_in = {4'($urandom()), zsel, 1'b0, 1'($urandom())};
            for (int i = 0; i < 12; i++) begin
                a_in       = 18'($urandom());
                b_in       = 18'($urandom());
                d_in       = 18'($urandom());
                bcin_in    = 18'($urandom());
                c_in       = 48'({$urandom(), $urandom()});
                pcin_in    = 48'({$urandom(), $urandom()});
                carryin_in = 1'($urandom());
                if (i == 11 && burst == 0) c_in = 48'hFFFF_FFFF_FFFF;
                step();
            end
        end
        rand_phase = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
